y_buf_arbiter: RTL and testbench

Shares the single port of the output (Y) buffer BRAM between the MLP result stream and a host readback port. The MLP stream comes from the global controller's y_en/y_wen/y_buf_addr and the PU result. The MLP side has no backpressure, so writes the port cannot take immediately go into a small write FIFO. Host reads get bounded latency through a starvation counter and a read-after-write hazard check. The block sits between the MLP core and the Y buffer BRAM in the accelerator top level.

---
 rtl/y_arb_pkg.sv | 24 ++
 rtl/y_wr_fifo.sv | 98 +++++++++
 rtl/y_buf_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_y_buf_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y_arb_pkg.sv
// Shared types for the Y buffer arbiter: host FSM states, port-source
// encoding and a pointer-width helper.
package y_arb_pkg;

    typedef enum logic [1:0] {
        H_IDLE,
        H_WAIT,
        H_ISSUE,
        H_DATA
    } host_state_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_HOST,
        SRC_FIFO,
        SRC_BYP
    } port_src_t;

    // Bits needed to index n entries (at least one bit).
    function automatic int ptr_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/y_wr_fifo.sv
// Small synchronous write FIFO of {addr, data} entries. Besides the usual
// head/count/full/empty it exposes every slot address plus a valid mask so
// the arbiter can detect host reads that would overtake a queued write.
module y_wr_fifo
    import y_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 push_i,
    input  logic [ADDR_WIDTH-1:0]                push_addr_i,
    input  logic [DATA_WIDTH-1:0]                push_data_i,
    input  logic                                 pop_i,
    output logic [ADDR_WIDTH-1:0]                head_addr_o,
    output logic [DATA_WIDTH-1:0]                head_data_o,
    output logic [ptr_w(DEPTH):0]                count_o,
    output logic                                 full_o,
    output logic                                 empty_o,
    output logic [DEPTH-1:0][ADDR_WIDTH-1:0]     ent_addr_o,
    output logic [DEPTH-1:0]                     ent_vld_o
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [ADDR_WIDTH-1:0] addr_mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] addr_mem_d [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem_d [DEPTH];
    logic [PTR_W-1:0]      ent_off [DEPTH];
    logic                  do_push, do_pop;

    assign full_o      = (count_q == CNT_W'(DEPTH));
    assign empty_o     = (count_q == '0);
    assign count_o     = count_q;
    assign head_addr_o = addr_mem_q[rd_ptr_q];
    assign head_data_o = data_mem_q[rd_ptr_q];

    // Push/pop qualification; a push onto a full FIFO only lands when the
    // head leaves in the same cycle (the slot being written is the head).
    always_comb begin
        do_pop     = pop_i && !empty_o;
        do_push    = push_i && (!full_o || do_pop);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        addr_mem_d = addr_mem_q;
        data_mem_d = data_mem_q;
        if (do_push) begin
            addr_mem_d[wr_ptr_q] = push_addr_i;
            data_mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d             = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Slot i is valid when its distance from the read pointer is below count.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_off[i]    = PTR_W'(i) - rd_ptr_q;
            ent_vld_o[i]  = ({1'b0, ent_off[i]} < count_q);
            ent_addr_o[i] = addr_mem_q[i];
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care until made valid by a push.
    always_ff @(posedge clk) begin
        addr_mem_q <= addr_mem_d;
        data_mem_q <= data_mem_d;
    end

endmodule

// File: rtl/y_buf_arbiter.sv
// Single-port Y buffer arbiter: MLP result writes (no backpressure, queued
// in a write FIFO when the port is taken) versus host readback with a
// starvation counter and a read-after-write hazard check on queued writes.
module y_buf_arbiter
    import y_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_WAIT   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mlp_en,
    input  logic                  mlp_wen,
    input  logic [ADDR_WIDTH-1:0] mlp_addr,
    input  logic [DATA_WIDTH-1:0] mlp_data,
    input  logic                  host_req,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    output logic                  host_ack,
    output logic                  host_rvalid,
    output logic [DATA_WIDTH-1:0] host_rdata,
    output logic                  bram_en,
    output logic                  bram_wen,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_din,
    input  logic [DATA_WIDTH-1:0] bram_dout,
    output logic                  ovf_o,
    output logic                  busy_o
);

    localparam int PTR_W = ptr_w(FIFO_DEPTH);
    localparam int CNT_W = ptr_w(MAX_WAIT + 1);

    host_state_t           state_q, state_d;
    logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;
    logic                  bram_en_q, bram_en_d;
    logic                  bram_wen_q, bram_wen_d;
    logic [ADDR_WIDTH-1:0] bram_addr_q, bram_addr_d;
    logic [DATA_WIDTH-1:0] bram_din_q, bram_din_d;
    logic                  host_rvalid_q, host_rvalid_d;
    logic [DATA_WIDTH-1:0] host_rdata_q, host_rdata_d;
    logic                  ovf_q, ovf_d;

    port_src_t             src;
    logic                  mlp_we, hazard, starved, host_cand;
    logic                  grant, push, pop;

    logic [ADDR_WIDTH-1:0]                 fifo_head_addr;
    logic [DATA_WIDTH-1:0]                 fifo_head_data;
    logic [PTR_W:0]                        fifo_count;
    logic                                  fifo_full, fifo_empty;
    logic [FIFO_DEPTH-1:0][ADDR_WIDTH-1:0] fifo_ent_addr;
    logic [FIFO_DEPTH-1:0]                 fifo_ent_vld;

    y_wr_fifo #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_addr_i (mlp_addr),
        .push_data_i (mlp_data),
        .pop_i       (pop),
        .head_addr_o (fifo_head_addr),
        .head_data_o (fifo_head_data),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .ent_addr_o  (fifo_ent_addr),
        .ent_vld_o   (fifo_ent_vld)
    );

    // Host address matches a queued write: reading now would return stale data.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (fifo_ent_vld[i] && (fifo_ent_addr[i] == host_addr)) begin
                hazard = 1'b1;
            end
        end
    end

    // Port arbitration: starved host, FIFO head, bypass, then ordinary host.
    always_comb begin
        mlp_we    = mlp_en && mlp_wen;
        starved   = (wait_cnt_q >= CNT_W'(MAX_WAIT));
        host_cand = (state_q == H_WAIT) && host_req && !hazard && !rst;
        src       = SRC_NONE;
        if (host_cand && starved) begin
            src = SRC_HOST;
        end else if (!fifo_empty) begin
            src = SRC_FIFO;
        end else if (mlp_we) begin
            src = SRC_BYP;
        end else if (host_cand) begin
            src = SRC_HOST;
        end
        grant = (src == SRC_HOST);
        pop   = (src == SRC_FIFO);
        push  = mlp_we && (src != SRC_BYP);
    end

    // Host FSM, starvation counter, port register and read-return next state.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = '0;
        bram_en_d     = (src != SRC_NONE);
        bram_wen_d    = (src == SRC_FIFO) || (src == SRC_BYP);
        bram_addr_d   = bram_addr_q;
        bram_din_d    = bram_din_q;
        host_rvalid_d = 1'b0;
        host_rdata_d  = host_rdata_q;
        ovf_d         = ovf_q || (push && fifo_full && !pop);

        case (state_q)
            H_IDLE:  if (host_req) state_d = H_WAIT;
            H_WAIT: begin
                if (grant) begin
                    state_d = H_ISSUE;
                end else begin
                    wait_cnt_d = starved ? wait_cnt_q : wait_cnt_q + 1'b1;
                end
            end
            H_ISSUE: state_d = H_DATA;
            H_DATA: begin
                host_rvalid_d = 1'b1;
                host_rdata_d  = bram_dout;
                state_d       = H_IDLE;
            end
            default: state_d = H_IDLE;
        endcase

        case (src)
            SRC_HOST: bram_addr_d = host_addr;
            SRC_FIFO: begin
                bram_addr_d = fifo_head_addr;
                bram_din_d  = fifo_head_data;
            end
            SRC_BYP: begin
                bram_addr_d = mlp_addr;
                bram_din_d  = mlp_data;
            end
            default: ;
        endcase
    end

    // State and output registers; everything visible returns to zero on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= H_IDLE;
            wait_cnt_q    <= '0;
            bram_en_q     <= 1'b0;
            bram_wen_q    <= 1'b0;
            bram_addr_q   <= '0;
            bram_din_q    <= '0;
            host_rvalid_q <= 1'b0;
            host_rdata_q  <= '0;
            ovf_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            bram_en_q     <= bram_en_d;
            bram_wen_q    <= bram_wen_d;
            bram_addr_q   <= bram_addr_d;
            bram_din_q    <= bram_din_d;
            host_rvalid_q <= host_rvalid_d;
            host_rdata_q  <= host_rdata_d;
            ovf_q         <= ovf_d;
        end
    end

    assign host_ack    = grant;
    assign host_rvalid = host_rvalid_q;
    assign host_rdata  = host_rdata_q;
    assign bram_en     = bram_en_q;
    assign bram_wen    = bram_wen_q;
    assign bram_addr   = bram_addr_q;
    assign bram_din    = bram_din_q;
    assign ovf_o       = ovf_q;
    assign busy_o      = (fifo_count != '0) || (state_q != H_IDLE);

endmodule

// File: tb/tb_y_buf_arbiter.sv
// Directed bench for y_buf_arbiter with a 1-cycle-latency BRAM model.
module tb_y_buf_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mlp_en = 1'b0, mlp_wen = 1'b0;
    logic [31:0] mlp_addr = '0, mlp_data = '0;
    logic        host_req = 1'b0;
    logic [31:0] host_addr = '0;
    logic        host_ack, host_rvalid;
    logic [31:0] host_rdata;
    logic        bram_en, bram_wen;
    logic [31:0] bram_addr, bram_din;
    logic [31:0] bram_dout = '0;
    logic        ovf_o, busy_o;

    y_buf_arbiter #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .FIFO_DEPTH (4),
        .MAX_WAIT   (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mlp_en      (mlp_en),
        .mlp_wen     (mlp_wen),
        .mlp_addr    (mlp_addr),
        .mlp_data    (mlp_data),
        .host_req    (host_req),
        .host_addr   (host_addr),
        .host_ack    (host_ack),
        .host_rvalid (host_rvalid),
        .host_rdata  (host_rdata),
        .bram_en     (bram_en),
        .bram_wen    (bram_wen),
        .bram_addr   (bram_addr),
        .bram_din    (bram_din),
        .bram_dout   (bram_dout),
        .ovf_o       (ovf_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // BRAM model: unwritten locations read as 0xDEAD0000 | addr.
    logic [31:0]  mem [256];
    logic [255:0] wr_seen = '0;
    always @(posedge clk) begin
        if (bram_en) begin
            if (bram_wen) begin
                mem[bram_addr[7:0]]     <= bram_din;
                wr_seen[bram_addr[7:0]] <= 1'b1;
            end else begin
                bram_dout <= wr_seen[bram_addr[7:0]] ? mem[bram_addr[7:0]]
                                                     : (32'hDEAD0000 | bram_addr);
            end
        end
    end

    // Port activity monitor, sampled on the falling edge.
    logic [31:0] wq_a[$], wq_d[$];
    int          wq_c[$];
    logic [31:0] rd_a = '0;
    int          rd_c = -1, ovf_c = -1, busy_cnt = 0, rv_cnt = 0;
    always @(negedge clk) begin
        if (bram_en && bram_wen) begin
            wq_a.push_back(bram_addr);
            wq_d.push_back(bram_din);
            wq_c.push_back(cyc);
        end
        if (bram_en && !bram_wen) begin
            rd_a = bram_addr;
            rd_c = cyc;
        end
        if (ovf_o && ovf_c < 0) ovf_c = cyc;
        if (busy_o) busy_cnt++;
        if (host_rvalid) rv_cnt++;
    end

    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) tick();
    endtask

    task automatic clear_log();
        wq_a.delete();
        wq_d.delete();
        wq_c.delete();
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_bram_en"},  64'(bram_en),     64'd0);
        chk({pfx, "_bram_wen"}, 64'(bram_wen),    64'd0);
        chk({pfx, "_addr"},     64'(bram_addr),   64'd0);
        chk({pfx, "_din"},      64'(bram_din),    64'd0);
        chk({pfx, "_ack"},      64'(host_ack),    64'd0);
        chk({pfx, "_rvalid"},   64'(host_rvalid), 64'd0);
        chk({pfx, "_rdata"},    64'(host_rdata),  64'd0);
        chk({pfx, "_ovf"},      64'(ovf_o),       64'd0);
        chk({pfx, "_busy"},     64'(busy_o),      64'd0);
    endtask

    // n back-to-back MLP writes; write k goes to base_a+k / base_d+k except
    // write hz_k, which carries hz_a / hz_d.
    task automatic stream(input int n, input int base_a, input int base_d,
                          input int hz_k, input logic [31:0] hz_a, input logic [31:0] hz_d);
        for (int k = 0; k < n; k++) begin
            if (k > 0) tick();
            mlp_en   = 1'b1;
            mlp_wen  = 1'b1;
            mlp_addr = (k == hz_k) ? hz_a : 32'(base_a + k);
            mlp_data = (k == hz_k) ? hz_d : 32'(base_d + k);
        end
        tick();
        mlp_en  = 1'b0;
        mlp_wen = 1'b0;
    endtask

    // One host read; reports ack cycle, rvalid cycle and returned data.
    task automatic host_rd(input logic [31:0] a, output int ack_c, output int rv_c,
                           output logic [31:0] rv_d);
        ack_c     = -1;
        rv_c      = -1;
        rv_d      = '0;
        host_addr = a;
        host_req  = 1'b1;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (host_ack) begin
                ack_c = cyc;
                break;
            end
        end
        tick();
        host_req = 1'b0;
        if (ack_c >= 0) begin
            for (int j = 0; j < 10; j++) begin
                @(negedge clk);
                if (host_rvalid) begin
                    rv_c = cyc;
                    rv_d = host_rdata;
                    break;
                end
            end
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int          s, r, aA, rA, aB, rB, ac, rc, k;
        logic [31:0] dA, dB, dd;
        int          acks [5];

        // Reset values
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk_zero("rst");

        // Bypass writes 0..9 / 100..109, one per cycle
        tick();
        s = cyc;
        busy_cnt = 0;
        clear_log();
        stream(10, 0, 100, -1, '0, '0);
        wait_until(s + 14);
        chk("byp_count", 64'(wq_a.size()), 64'd10);
        for (int i = 0; i < 10 && i < wq_a.size(); i++) begin
            chk($sformatf("byp_a%0d", i), 64'(wq_a[i]), 64'(i));
            chk($sformatf("byp_d%0d", i), 64'(wq_d[i]), 64'(100 + i));
            chk($sformatf("byp_c%0d", i), 64'(wq_c[i]), 64'(s + 1 + i));
        end
        chk("byp_busy", 64'(busy_cnt), 64'd0);
        chk("byp_ovf", 64'(ovf_o), 64'd0);

        // Idle host read of address 5
        tick();
        r = cyc;
        host_rd(32'd5, ac, rc, dd);
        chk("rd5_ack", 64'(ac), 64'(r + 1));
        chk("rd5_bram_c", 64'(rd_c), 64'(r + 2));
        chk("rd5_bram_a", 64'(rd_a), 64'd5);
        chk("rd5_rv_c", 64'(rc), 64'(r + 4));
        chk("rd5_data", 64'(dd), 64'd105);

        // Starved read (addr 60) under a write stream, then hazard read of addr 3
        tick();
        s = cyc;
        clear_log();
        fork
            stream(25, 70, 300, 21, 32'd3, 32'hAB);
            begin
                host_rd(32'd60, aA, rA, dA);
                host_rd(32'd3, aB, rB, dB);
            end
        join
        wait_until(s + 34);
        chk("starve_ack", 64'(aA), 64'(s + 9));
        chk("starve_data", 64'(dA), 64'h0000_0000_DEAD_003C);
        chk("hz_ack", 64'(aB), 64'(s + 23));
        chk("hz_bram_rd_c", 64'(rd_c), 64'(s + 24));
        chk("hz_data", 64'(dB), 64'hAB);
        chk("hz_count", 64'(wq_a.size()), 64'd25);
        if (wq_a.size() > 21) chk("hz_wr_c", 64'(wq_c[21]), 64'(s + 23));
        for (int i = 0; i < 25 && i < wq_a.size(); i++) begin
            chk($sformatf("st_a%0d", i), 64'(wq_a[i]), (i == 21) ? 64'd3 : 64'(70 + i));
            chk($sformatf("st_d%0d", i), 64'(wq_d[i]), (i == 21) ? 64'hAB : 64'(300 + i));
        end
        chk("st_busy_end", 64'(busy_o), 64'd0);
        chk("st_ovf", 64'(ovf_o), 64'd0);

        // Fill the FIFO with five starved host reads; write 61 is dropped
        tick();
        s = cyc;
        ovf_c = -1;
        clear_log();
        fork
            stream(64, 140, 5000, -1, '0, '0);
            begin
                for (int i = 0; i < 5; i++) begin
                    wait_until(s + 13 * i);
                    host_rd(32'(40 + i), acks[i], rc, dd);
                end
            end
        join
        wait_until(s + 75);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("ovf_ack%0d", i), 64'(acks[i]), 64'(s + 13 * i + 9));
        end
        chk("ovf_count", 64'(wq_a.size()), 64'd63);
        for (int j = 0; j < 63 && j < wq_a.size(); j++) begin
            k = (j < 61) ? j : j + 1;
            chk($sformatf("ovf_a%0d", j), 64'(wq_a[j]), 64'(140 + k));
            chk($sformatf("ovf_d%0d", j), 64'(wq_d[j]), 64'(5000 + k));
        end
        chk("ovf_rise_c", 64'(ovf_c), 64'(s + 62));
        chk("ovf_sticky", 64'(ovf_o), 64'd1);
        chk("ovf_busy_end", 64'(busy_o), 64'd0);

        // Reset in the cycle after host_ack, with a write queued
        tick();
        r = cyc;
        ac = -1;
        fork
            stream(11, 90, 900, -1, '0, '0);
            begin
                host_addr = 32'd8;
                host_req  = 1'b1;
                for (int j = 0; j < 40; j++) begin
                    @(negedge clk);
                    if (host_ack) begin
                        ac = cyc;
                        break;
                    end
                end
                tick();
                rst      = 1'b1;
                host_req = 1'b0;
                rv_cnt   = 0;
                tick();
                rst = 1'b0;
            end
        join
        @(negedge clk);
        chk("mid_ack", 64'(ac), 64'(r + 9));
        chk_zero("mid_rst");
        clear_log();
        repeat (6) tick();
        chk("mid_no_rvalid", 64'(rv_cnt), 64'd0);
        r = cyc;
        mlp_en   = 1'b1;
        mlp_wen  = 1'b1;
        mlp_addr = 32'd11;
        mlp_data = 32'h55;
        tick();
        mlp_en  = 1'b0;
        mlp_wen = 1'b0;
        repeat (3) tick();
        chk("post_count", 64'(wq_a.size()), 64'd1);
        if (wq_a.size() > 0) begin
            chk("post_a", 64'(wq_a[0]), 64'd11);
            chk("post_d", 64'(wq_d[0]), 64'h55);
            chk("post_c", 64'(wq_c[0]), 64'(r + 1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
